// File: rtl/rs_syndrome_sequencer.sv
// Serial RS(18,16) syndrome generator: S1/S2 by Horner's rule,
// one symbol per clock through two shared GF(2^8) mul/add pairs.
module rs_syndrome_sequencer #(
  parameter int N = 18,
  parameter int SYMBOL_WIDTH = 8,
  parameter logic [SYMBOL_WIDTH-1:0] ROOT1 = 8'h02,
  parameter logic [SYMBOL_WIDTH-1:0] ROOT2 = 8'h04,
  parameter logic [SYMBOL_WIDTH:0] POLY = 9'h11D
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*SYMBOL_WIDTH-1:0] v,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SYMBOL_WIDTH-1:0]   s1,
  output logic [SYMBOL_WIDTH-1:0]   s2,
  output logic                      err_detected,
  output logic                      busy
);

  localparam int SW = SYMBOL_WIDTH;
  localparam int IDX_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [SW-1:0]    cw [N];
  logic [SW-1:0]    acc1;
  logic [SW-1:0]    acc2;
  logic [IDX_W-1:0] idx;
  logic [SW-1:0]    sym;
  logic [SW-1:0]    mul1;
  logic [SW-1:0]    mul2;
  logic             accept;

  // Shift-and-add multiply, reducing by POLY on every carry out.
  function automatic logic [SW-1:0] gf_mul(
    input logic [SW-1:0] a,
    input logic [SW-1:0] b
  );
    logic [SW-1:0] p;
    logic [SW-1:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < SW; k++) begin
      if (b[k]) p = p ^ x;
      if (x[SW-1]) x = (x << 1) ^ POLY[SW-1:0];
      else x = x << 1;
    end
    return p;
  endfunction

  assign sym  = cw[idx];
  assign mul1 = gf_mul(acc1, ROOT1);
  assign mul2 = gf_mul(acc2, ROOT2);

  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (idx == '0) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Highest symbol first, so the last step adds v_0 unscaled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      acc1 <= '0;
      acc2 <= '0;
      for (int k = 0; k < N; k++) cw[k] <= '0;
    end else if (accept) begin
      idx  <= IDX_W'(N - 1);
      acc1 <= '0;
      acc2 <= '0;
      for (int k = 0; k < N; k++) cw[k] <= v[k*SW +: SW];
    end else if (state == CALC) begin
      acc1 <= mul1 ^ sym;
      acc2 <= mul2 ^ sym;
      if (idx != '0) idx <= idx - 1'b1;
    end
  end

  assign s1 = acc1;
  assign s2 = acc2;
  assign err_detected = (acc1 != '0) || (acc2 != '0);

endmodule
